// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: config bus and trap handshake between the interrupt controller and the core.
interface irq_ctrl_if #(
  parameter int IDW = 5
);
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [31:0]    cfg_wdata;
  logic [31:0]    cfg_rdata;
  logic           irq_out;
  logic [IDW-1:0] irq_id;
  logic           trap_ack;
  logic           mret_in;
  logic           in_service;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, trap_ack, mret_in,
    input  cfg_rdata, irq_out, irq_id, in_service
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, trap_ack, mret_in,
    output cfg_rdata, irq_out, irq_id, in_service
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered, fixed-priority interrupt controller sequencing one machine-mode
// interrupt at a time through request, trap acknowledge and mret.
module irq_ctrl #(
  parameter int NSRC        = 8,
  parameter int IDW         = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  irq_ctrl_if.slave       bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_d [SYNC_STAGES];
  logic [NSRC-1:0] last_q, last_d, hist_q, hist_d;
  logic [NSRC-1:0] en_q, en_d, pend_q, pend_d;
  logic [NSRC-1:0] act, rise, w1c, claim, sel;
  logic [1:0]      state_q, state_d;
  logic            irq_q, irq_d, svc_q, svc_d;
  logic [IDW-1:0]  id_q, id_d, win;
  logic [31:0]     rdata;
  logic            hold, unused_ok;
  always_comb begin
    sync_d[0] = src_irq;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    last_d = sync_q[SYNC_STAGES-1];
    hist_d = last_q;
  end
  // Registered edge compare keeps the rise pulse one cycle clear of the synchroniser output.
  always_comb begin
    rise  = last_q & ~hist_q;
    act   = pend_q & en_q;
    sel   = NSRC'(1) << id_q;
    hold  = |(act & sel);
    claim = (state_q == S_REQ && bus.trap_ack) ? sel : '0;
    w1c   = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[NSRC-1:0] : '0;
    en_d  = (bus.cfg_we && bus.cfg_addr == 2'd0) ? bus.cfg_wdata[NSRC-1:0] : en_q;
    pend_d = (pend_q & ~w1c & ~claim) | rise;
  end
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (act[i]) win = IDW'(i);
  end
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    svc_d   = svc_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: if (|act) begin
        state_d = S_REQ;
        irq_d   = 1'b1;
        id_d    = win;
      end
      S_REQ: if (bus.trap_ack) begin
        state_d = S_SVC;
        irq_d   = 1'b0;
        svc_d   = 1'b1;
      end else if (!hold) begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
      S_SVC: if (bus.mret_in) begin
        state_d = S_COOL;
        svc_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      2'd0: rdata[NSRC-1:0] = en_q;
      2'd1: rdata[NSRC-1:0] = pend_q;
      2'd2: begin
        rdata[31]      = svc_q;
        rdata[IDW-1:0] = id_q;
      end
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q  <= '0;
      hist_q  <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      svc_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      last_q  <= last_d;
      hist_q  <= hist_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      irq_q   <= irq_d;
      svc_q   <= svc_d;
      id_q    <= id_d;
    end
  end
  assign bus.cfg_rdata  = rdata;
  assign bus.irq_out    = irq_q;
  assign bus.irq_id     = id_q;
  assign bus.in_service = svc_q;
  assign unused_ok      = ^bus.cfg_wdata;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and random stimulus checked every cycle against a cycle-level
// reference model of the interrupt controller built from sampled-input history.
module tb_irq_ctrl;
  localparam int NSRC = 8;
  localparam int IDW  = 5;
  localparam int SS   = 2;
  localparam int D    = SS + 1;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] src_irq = '0;
  int              checks = 0;
  int              errors = 0;
  irq_ctrl_if #(.IDW(IDW)) bus ();
  irq_ctrl #(.NSRC(NSRC), .IDW(IDW), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_irq (src_irq),
    .bus     (bus.slave)
  );
  always #5 clk = ~clk;
  logic [NSRC-1:0] m_samp [D+1];
  logic [NSRC-1:0] m_pend = '0;
  logic [NSRC-1:0] m_en = '0;
  logic [IDW-1:0]  m_id = '0;
  int              m_phase = 0;
  logic            m_irq = 1'b0;
  logic            m_svc = 1'b0;
  // Model: a source bit rising in the sample stream becomes pending D edges later.
  always @(posedge clk) begin : model
    logic [NSRC-1:0] set_v, clr_v;
    int w;
    if (!rst) begin
      for (int j = 0; j <= D; j++) m_samp[j] <= '0;
      m_pend  <= '0;
      m_en    <= '0;
      m_id    <= '0;
      m_phase <= 0;
      m_irq   <= 1'b0;
      m_svc   <= 1'b0;
    end else begin
      set_v = m_samp[D-1] & ~m_samp[D];
      m_samp[0] <= src_irq;
      for (int j = 1; j <= D; j++) m_samp[j] <= m_samp[j-1];
      clr_v = '0;
      if (bus.cfg_we && bus.cfg_addr == 2'd1) clr_v = bus.cfg_wdata[NSRC-1:0];
      if (m_phase == 1 && bus.trap_ack) clr_v = clr_v | (NSRC'(1) << m_id);
      m_pend <= (m_pend & ~clr_v) | set_v;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) m_en <= bus.cfg_wdata[NSRC-1:0];
      case (m_phase)
        0: begin
          w = -1;
          for (int i = 0; i < NSRC; i++) if (w < 0 && m_pend[i] && m_en[i]) w = i;
          if (w >= 0) begin
            m_phase <= 1;
            m_id    <= IDW'(w);
            m_irq   <= 1'b1;
          end
        end
        1: if (bus.trap_ack) begin
          m_phase <= 2;
          m_irq   <= 1'b0;
          m_svc   <= 1'b1;
        end else if ((m_pend & m_en & (NSRC'(1) << m_id)) == '0) begin
          m_phase <= 0;
          m_irq   <= 1'b0;
        end
        2: if (bus.mret_in) begin
          m_phase <= 3;
          m_svc   <= 1'b0;
        end
        default: m_phase <= 0;
      endcase
    end
  end
  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_en);
      2'd1:    return 32'(m_pend);
      2'd2:    return {m_svc, 26'b0, m_id};
      default: return 32'h0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model_irq_out", 32'(bus.irq_out), 32'(m_irq));
    chk("model_irq_id", 32'(bus.irq_id), 32'(m_id));
    chk("model_in_service", 32'(bus.in_service), 32'(m_svc));
    chk("model_rdata", bus.cfg_rdata, m_read(bus.cfg_addr));
  endtask
  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(tag, bus.cfg_rdata, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask
  task automatic pulse_src(input logic [NSRC-1:0] m);
    src_irq = m;
    tick();
    src_irq = '0;
  endtask
  task automatic ack();
    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0;
  endtask
  task automatic mret();
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
  endtask
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_wdata = '0;
    bus.trap_ack = 1'b0;
    bus.mret_in = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    chk("reset_irq_out", 32'(bus.irq_out), 32'h0);
    chk("reset_in_service", 32'(bus.in_service), 32'h0);
    rdchk("reset_enable", 2'd0, 32'h0);
    rdchk("reset_pending", 2'd1, 32'h0);
    // single source: pending at k+3, request at k+4
    wr(2'd0, 32'h1);
    rdchk("enable_readback", 2'd0, 32'h1);
    pulse_src(8'h01);
    tick();
    tick();
    rdchk("pend_not_yet_k2", 2'd1, 32'h0);
    tick();
    rdchk("pend_at_k3", 2'd1, 32'h1);
    chk("irq_low_at_k3", 32'(bus.irq_out), 32'h0);
    tick();
    chk("irq_high_at_k4", 32'(bus.irq_out), 32'h1);
    chk("irq_id_src0", 32'(bus.irq_id), 32'h0);
    ack();
    chk("ack_irq_low", 32'(bus.irq_out), 32'h0);
    chk("ack_in_service", 32'(bus.in_service), 32'h1);
    rdchk("ack_clears_pend", 2'd1, 32'h0);
    rdchk("status_in_service", 2'd2, 32'h8000_0000);
    mret();
    chk("mret_svc_low", 32'(bus.in_service), 32'h0);
    tick();
    // fixed priority and two-edge re-request after mret
    wr(2'd0, 32'hFF);
    pulse_src(8'h24);
    repeat (4) tick();
    chk("prio_irq", 32'(bus.irq_out), 32'h1);
    chk("prio_id2", 32'(bus.irq_id), 32'h2);
    ack();
    mret();
    chk("cool_irq_low", 32'(bus.irq_out), 32'h0);
    tick();
    chk("mret_plus1_low", 32'(bus.irq_out), 32'h0);
    tick();
    chk("mret_plus2_high", 32'(bus.irq_out), 32'h1);
    chk("prio_id5", 32'(bus.irq_id), 32'h5);
    ack();
    mret();
    tick();
    // masking and withdrawal by W1C
    wr(2'd0, 32'h0);
    pulse_src(8'h08);
    repeat (3) tick();
    rdchk("masked_pend", 2'd1, 32'h08);
    tick();
    chk("masked_no_irq", 32'(bus.irq_out), 32'h0);
    wr(2'd0, 32'h08);
    tick();
    chk("unmask_irq", 32'(bus.irq_out), 32'h1);
    rdchk("unmask_status_id3", 2'd2, 32'h3);
    wr(2'd1, 32'h08);
    tick();
    chk("withdraw_irq_low", 32'(bus.irq_out), 32'h0);
    rdchk("withdraw_pend", 2'd1, 32'h0);
    rdchk("addr3_zero", 2'd3, 32'h0);
    // new edge coinciding with trap_ack keeps the pending bit
    wr(2'd0, 32'h02);
    pulse_src(8'h02);
    repeat (4) tick();
    chk("src1_irq", 32'(bus.irq_out), 32'h1);
    pulse_src(8'h02);
    tick();
    tick();
    ack();
    chk("setwins_svc", 32'(bus.in_service), 32'h1);
    rdchk("setwins_pend", 2'd1, 32'h02);
    mret();
    tick();
    tick();
    chk("rereq_irq", 32'(bus.irq_out), 32'h1);
    chk("rereq_id1", 32'(bus.irq_id), 32'h1);
    ack();
    mret();
    tick();
    // spurious handshakes
    ack();
    chk("spur_ack_irq", 32'(bus.irq_out), 32'h0);
    chk("spur_ack_svc", 32'(bus.in_service), 32'h0);
    pulse_src(8'h02);
    repeat (4) tick();
    mret();
    chk("spur_mret_irq", 32'(bus.irq_out), 32'h1);
    chk("spur_mret_svc", 32'(bus.in_service), 32'h0);
    ack();
    chk("svc_before_rst", 32'(bus.in_service), 32'h1);
    // reset mid-service
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_svc", 32'(bus.in_service), 32'h0);
    chk("rst_irq", 32'(bus.irq_out), 32'h0);
    rdchk("rst_enable", 2'd0, 32'h0);
    rdchk("rst_pending", 2'd1, 32'h0);
    tick();
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      src_irq = src_irq ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      bus.cfg_we = ($urandom_range(7) == 0);
      bus.cfg_addr = 2'($urandom_range(3));
      bus.cfg_wdata = $urandom;
      bus.trap_ack = ($urandom_range(2) == 0);
      bus.mret_in = ($urandom_range(3) == 0);
      rst = ($urandom_range(399) != 0);
      tick();
    end
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.trap_ack = 1'b0;
    bus.mret_in = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Platform interrupt controller that drives the single `interrupt` input of the trap/exception unit. It collects NSRC external interrupt sources, synchronises and edge-detects them, and holds them as pending bits. It arbitrates pending and enabled sources by fixed priority and sequences one machine-mode interrupt at a time through a request/acknowledge/mret handshake. A small CSR-style config port gives software enable-mask control and pending-bit control.

Parameters:
NSRC, 8, number of interrupt sources (1..32)
IDW, 5, width of the source-id field (must satisfy 2^IDW >= NSRC)
SYNC_STAGES, 2, synchroniser flops per source (>=1)

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-low reset; all state resets on a rising clk edge while rst==0
src_irq  input  NSRC  asynchronous level sources; a rising edge raises a request
cfg_we  input  1  config write strobe
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data (combinational from cfg_addr)
irq_out  output  1  interrupt request to the exception unit's `interrupt` input
irq_id  output  IDW  id of the requested or in-service source
trap_ack  input  1  one-cycle pulse: exception unit has taken the interrupt trap
mret_in  input  1  one-cycle pulse: mret retired
in_service  output  1  an interrupt is being serviced

Behaviour:
- Reset (rst==0 at posedge): synchroniser flops=0, edge-history=0, enable=0, pending=0, state=IDLE, irq_out=0, irq_id=0, in_service=0. Reset mid-handshake returns to IDLE immediately; any in-flight trap_ack or mret_in in that cycle is ignored.
- Synchronisation and edge detection:
  - Each src_irq bit passes through SYNC_STAGES flops.
  - A 0->1 transition at the last stage sets pending[i].
  - If src_irq rises and is first sampled at edge k, pending[i]=1 after edge k+SYNC_STAGES+1. With the default, that is k+3.
  - Level-high with no new edge does not re-set a cleared bit.
- Config map:
  - addr0: enable mask (RW; bits above NSRC read 0, writes ignored).
  - addr1: pending (read; write-1-to-clear).
  - addr2: read-only {in_service at bit31, 0s, irq_id at [IDW-1:0]}.
  - addr3: reads 0.
  - Writes to addr2 and addr3 are ignored.
- Pending-bit priority in one cycle: a new edge set wins over W1C and over claim-clear for the same bit.
- Arbitration: the winner is the lowest index i with pending[i]&enable[i].
- FSM (registered outputs):
  - IDLE: irq_out=0, in_service=0. If any pending&enable, go to REQ next edge; irq_id<=winner and irq_out<=1. Default timing: irq_out is high after edge k+4.
  - REQ:
    - irq_out=1 and irq_id are frozen; later higher-priority arrivals do not preempt.
    - trap_ack: go to SERVICE, clear pending[irq_id] (subject to the set-wins rule), irq_out<=0, in_service<=1.
    - If pending[irq_id]&enable[irq_id] becomes 0 (via W1C or enable write) with no trap_ack that cycle: withdraw to IDLE, irq_out<=0.
    - trap_ack and withdrawal in the same cycle: trap_ack wins.
  - SERVICE: irq_out=0, in_service=1. No nesting. mret_in moves to COOL and in_service<=0.
  - COOL: one cycle with irq_out=0, to let the flushed pipeline refill; then IDLE. A new request is therefore raised no earlier than 2 edges after mret_in.
- Ignored inputs: trap_ack outside REQ; mret_in outside SERVICE.
- irq_id holds its last value in IDLE, SERVICE and COOL.

Test Plan:
- Reset then single source: rst low 2 cycles, write enable=0x01, pulse src_irq[0] high at edge k -> pending=0x01 at k+3, irq_out=1 and irq_id=0 at k+4; trap_ack -> irq_out=0, in_service=1, pending=0; mret_in -> in_service=0, IDLE after COOL.
- Priority: enable=0xFF, raise src 5 and 2 together -> irq_id=2; after ack+mret, irq_id=5 and irq_out reasserts exactly 2 edges after mret_in.
- Masking and withdrawal: enable=0x00, edge on src 3 -> pending=0x08, irq_out stays 0; write enable=0x08 -> REQ, irq_id=3; write addr1=0x08 (W1C) before ack -> irq_out=0, back to IDLE, pending=0.
- Simultaneous set and clear: in the same cycle, trap_ack for id 1 and a new edge on src 1 -> pending[1] remains 1; a second request for id 1 follows after mret and COOL.
- Spurious handshakes: trap_ack in IDLE and mret_in in REQ -> no state change, irq_out unchanged.
- Reset mid-service: in SERVICE, assert rst=0 for one edge -> in_service=0, irq_out=0, enable=0, pending=0 the next cycle.
